// File: rtl/ov7670_capture_ctrl.sv
// ----------------------------------------------------------------------------
// ov7670_capture_ctrl
//   Captures RGB565 pixels from an OV7670 camera port and turns them into
//   linear frame buffer writes. The camera pins are sampled in the i_clk
//   domain. Edges of PCLK, VSYNC and HREF are detected on the synchronised
//   copies.
//
// Ports
//   i_clk, i_reset_n   system clock, asynchronous active-low reset
//   i_pclk, i_vsync,   raw camera pins, asynchronous to i_clk
//   i_href, i_data
//   i_capture_en       level; high keeps capturing frames back to back
//   o_wr_en            one-cycle write strobe
//   o_wr_addr          write address
//   o_wr_data          RGB565 pixel {first byte, second byte}
//   o_frame_done       one-cycle pulse at frame end
//   o_frame_cnt        completed frame count, wraps 255 -> 0
//   o_busy             high whenever the controller is not idle
//   o_err              sticky format error, cleared when a new capture arms
//
// Write port semantics: o_wr_en is a one-cycle strobe with no back-pressure.
// The frame buffer must accept a write in every cycle where o_wr_en=1.
// o_wr_addr and o_wr_data are valid while o_wr_en=1 and then hold until
// the next write.
// ----------------------------------------------------------------------------
module ov7670_capture_ctrl #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_pclk,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [7:0]        i_data,
  input  logic              i_capture_en,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_frame_done,
  output logic [7:0]        o_frame_cnt,
  output logic              o_busy,
  output logic              o_err
);

  // The counters are wide enough to hold the saturation value itself.
  localparam int PW = $clog2(H_PIXELS + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [PW-1:0]     H_P    = PW'(H_PIXELS);
  localparam logic [LW-1:0]     V_L    = LW'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t r_state;

  // Two-flop synchronisers. Every pin has the same depth, so data stays
  // aligned with pclk. The *_prev stage feeds edge detection.
  logic r_pclk_s1,  r_pclk_s2,  r_pclk_prev;
  logic r_vsync_s1, r_vsync_s2, r_vsync_prev;
  logic r_href_s1,  r_href_s2,  r_href_prev;
  logic [7:0] r_data_s1, r_data_s2;

  logic [PW-1:0]     r_pix_cnt;
  logic [LW-1:0]     r_line_cnt;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_phase;
  logic [7:0]        r_high;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_frame_done;
  logic [7:0]        r_frame_cnt;
  logic              r_err;

  logic w_pclk_rise;
  logic w_vsync_rise;
  logic w_vsync_fall;
  logic w_href_fall;
  logic w_pix_ok;

  assign w_pclk_rise  =  r_pclk_s2  & ~r_pclk_prev;
  assign w_vsync_rise =  r_vsync_s2 & ~r_vsync_prev;
  assign w_vsync_fall = ~r_vsync_s2 &  r_vsync_prev;
  assign w_href_fall  = ~r_href_s2  &  r_href_prev;
  assign w_pix_ok     = (r_pix_cnt < H_P) && (r_line_cnt < V_L);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_pclk_s1    <= 1'b0;
      r_pclk_s2    <= 1'b0;
      r_pclk_prev  <= 1'b0;
      r_vsync_s1   <= 1'b0;
      r_vsync_s2   <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_href_s1    <= 1'b0;
      r_href_s2    <= 1'b0;
      r_href_prev  <= 1'b0;
      r_data_s1    <= '0;
      r_data_s2    <= '0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_line_base  <= '0;
      r_phase      <= 1'b0;
      r_high       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_pclk_s1    <= i_pclk;
      r_pclk_s2    <= r_pclk_s1;
      r_pclk_prev  <= r_pclk_s2;
      r_vsync_s1   <= i_vsync;
      r_vsync_s2   <= r_vsync_s1;
      r_vsync_prev <= r_vsync_s2;
      r_href_s1    <= i_href;
      r_href_s2    <= r_href_s1;
      r_href_prev  <= r_href_s2;
      r_data_s1    <= i_data;
      r_data_s2    <= r_data_s1;

      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_capture_en) begin
            r_state <= ST_ARMED;
            r_err   <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (w_vsync_fall) begin
            r_state     <= ST_FRAME;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_line_base <= '0;
            r_phase     <= 1'b0;
          end
        end

        ST_FRAME: begin
          if (w_vsync_rise) begin
            // Frame end wins over any pclk edge seen in the same cycle.
            r_state      <= i_capture_en ? ST_ARMED : ST_IDLE;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 8'd1;
          end else begin
            if (w_pclk_rise && r_href_s2) begin
              if (!r_phase) begin
                r_high  <= r_data_s2;
                r_phase <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (w_pix_ok) begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_line_base + ADDR_W'(r_pix_cnt);
                  r_wr_data <= {r_high, r_data_s2};
                end else begin
                  r_err <= 1'b1;
                end
                // Saturate at H_PIXELS. Every later pixel in the line is
                // dropped anyway.
                if (r_pix_cnt < H_P) r_pix_cnt <= r_pix_cnt + PW'(1);
              end
            end
            // An href fall implies synced href=0, so it never coincides with
            // a processed byte. The line-end update is applied last.
            if (w_href_fall) begin
              r_pix_cnt <= '0;
              if (r_line_cnt < V_L) begin
                r_line_cnt  <= r_line_cnt + LW'(1);
                r_line_base <= r_line_base + H_STEP;
              end
              if (r_phase) begin
                r_phase <= 1'b0;
                r_err   <= 1'b1;
              end
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ov7670_capture_ctrl
//   Bench for ov7670_capture_ctrl with a small 4x2 frame geometry.
// ----------------------------------------------------------------------------
module tb_ov7670_capture_ctrl;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 17;

  // clock / reset / pins
  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          pclk   = 1'b0;
  logic          vsync  = 1'b1;
  logic          href   = 1'b0;
  logic [7:0]    data   = 8'h00;
  logic          cap_en = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic [7:0]    frame_cnt;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  ov7670_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_pclk       (pclk),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_data       (data),
    .i_capture_en (cap_en),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_frame_done (frame_done),
    .o_frame_cnt  (frame_cnt),
    .o_busy       (busy),
    .o_err        (err)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [AW+15:0] exp_q[$];
  logic [AW+15:0] act_q[$];
  int done_cnt = 0;
  int m_frames = 0;
  bit m_err    = 1'b0;
  int m_line   = 0;

  typedef struct {
    int lines;
    int bytes;
    int exp_wr;
    bit exp_err;
  } vec_t;
  vec_t tbl[6];

  // Collect every write and frame_done pulse, sampled 1 ns after the clock edge.
  always @(posedge clk) begin
    #1;
    if (wr_en) act_q.push_back({wr_addr, wr_data});
    if (frame_done) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: timeout reached, compared %0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pclk_half();
    wait_cyc($urandom_range(2, 5));
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    pclk_half();
    pclk = 1'b1;
    pclk_half();
    pclk = 1'b0;
  endtask

  // Drive one HREF line and extend the reference model with the pixels that
  // the camera rules say land in the buffer.
  task automatic send_line(input int nbytes);
    logic [7:0] bytes[$];
    logic [7:0] b;
    href = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      send_byte(b);
    end
    wait_cyc(3);
    href = 1'b0;
    wait_cyc(6);
    for (int p = 0; p < nbytes / 2; p++) begin
      if (p < H && m_line < V)
        exp_q.push_back({AW'(m_line * H + p), bytes[2*p], bytes[2*p+1]});
      else
        m_err = 1'b1;
    end
    if (nbytes % 2 == 1) m_err = 1'b1;
    m_line++;
  endtask

  task automatic frame_start();
    wait_cyc(4);
    vsync = 1'b0;
    wait_cyc(6);
    m_line = 0;
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    wait_cyc(8);
    m_frames++;
  endtask

  task automatic check_frame(input string tag, input int exp_wr, input bit exp_e);
    int n;
    check({tag, "_nwr_model"}, act_q.size(), exp_q.size());
    check({tag, "_nwr_table"}, act_q.size(), exp_wr);
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
    check({tag, "_err_model"}, err, m_err);
    check({tag, "_err_table"}, err, exp_e);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_frame_cnt"}, frame_cnt, 8'(m_frames % 256));
    act_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    int nwrap;
    tbl[0] = '{lines: 2, bytes: 8,  exp_wr: 8, exp_err: 1'b0};
    tbl[1] = '{lines: 2, bytes: 12, exp_wr: 8, exp_err: 1'b1};
    tbl[2] = '{lines: 3, bytes: 8,  exp_wr: 8, exp_err: 1'b1};
    tbl[3] = '{lines: 2, bytes: 7,  exp_wr: 6, exp_err: 1'b1};
    tbl[4] = '{lines: 1, bytes: 4,  exp_wr: 2, exp_err: 1'b0};
    tbl[5] = '{lines: 2, bytes: 2,  exp_wr: 2, exp_err: 1'b0};

    // reset state
    wait_cyc(4);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    wait_cyc(3);

    // write latency from a known pclk sampling edge
    cap_en = 1'b1;
    m_err  = 1'b0;
    frame_start();
    href = 1'b1;
    wait_cyc(2);
    send_byte(8'hA5);
    data = 8'h3C;
    wait_cyc(4);
    pclk = 1'b1;              // first sampled at the next posedge (edge k)
    @(posedge clk); #1;
    check("lat_k", wr_en, 0);
    @(posedge clk); #1;
    check("lat_k1", wr_en, 0);
    @(posedge clk); #1;
    check("lat_k2", wr_en, 1);
    check("lat_addr", wr_addr, 0);
    check("lat_data", wr_data, 16'hA53C);
    @(posedge clk); #1;
    check("lat_k3", wr_en, 0);
    wait_cyc(2);
    pclk = 1'b0;
    wait_cyc(3);
    href = 1'b0;
    wait_cyc(6);
    exp_q.push_back({AW'(0), 16'hA53C});
    cap_en = 1'b0;
    frame_end();
    check("lat_idle", busy, 0);
    check_frame("lat", 1, 1'b0);

    // table-driven frames; capture_en drops mid-frame each time
    for (int t = 0; t < 6; t++) begin
      cap_en = 1'b1;
      wait_cyc(3);
      m_err = 1'b0;
      check($sformatf("t%0d_armed_busy", t), busy, 1);
      check($sformatf("t%0d_armed_err", t), err, 0);
      frame_start();
      for (int l = 0; l < tbl[t].lines; l++) begin
        send_line(tbl[t].bytes);
        if (l == 0) cap_en = 1'b0;
      end
      frame_end();
      check($sformatf("t%0d_idle_after", t), busy, 0);
      check_frame($sformatf("t%0d", t), tbl[t].exp_wr, tbl[t].exp_err);
    end

    // reset asserted mid-frame with writes active
    cap_en = 1'b1;
    frame_start();
    href = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    wait_cyc(2);
    rst_n = 1'b0;
    #1;
    check("mrst_wr_en", wr_en, 0);
    check("mrst_addr", wr_addr, 0);
    check("mrst_data", wr_data, 0);
    check("mrst_fcnt", frame_cnt, 0);
    check("mrst_busy", busy, 0);
    check("mrst_err", err, 0);
    check("mrst_nwr_before", act_q.size(), 3);
    act_q.delete();
    exp_q.delete();
    done_cnt = 0;
    m_frames = 0;
    wait_cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    wait_cyc(3);
    href = 1'b0;
    wait_cyc(6);
    check("mrst_nwr_after", act_q.size(), 0);
    check("mrst_armed", busy, 1);
    vsync = 1'b1;
    wait_cyc(8);
    check("mrst_no_done", done_cnt, 0);

    // continuous capture: err stays sticky across frames
    m_err = 1'b0;
    frame_start(); send_line(8); send_line(8); frame_end();
    check("cA_busy", busy, 1);
    check_frame("cA", 8, 1'b0);
    frame_start(); send_line(7); send_line(7); frame_end();
    check_frame("cB", 6, 1'b1);
    frame_start(); send_line(8); send_line(8); frame_end();
    check_frame("cC", 8, 1'b1);

    // vsync rise coincides with a pixel-completing pclk rise: no write
    frame_start();
    send_line(8);
    href = 1'b1;
    wait_cyc(2);
    send_byte(8'h11);
    data = 8'h22;
    wait_cyc(3);
    pclk  = 1'b1;
    vsync = 1'b1;
    wait_cyc(4);
    pclk = 1'b0;
    href = 1'b0;
    wait_cyc(8);
    m_frames++;
    check_frame("vsim", 4, 1'b1);

    // frame counter wrap
    nwrap = 0;
    while (m_frames % 256 != 255) begin
      frame_start();
      frame_end();
      nwrap++;
    end
    check("wrap_done_cnt", done_cnt, nwrap);
    check("wrap_255", frame_cnt, 8'd255);
    frame_start();
    frame_end();
    check("wrap_0", frame_cnt, 8'd0);
    check("wrap_nwr", act_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_capture_ctrl.md
# ov7670_capture_ctrl

Sequences pixel capture from the OV7670 camera port into the frame buffer write port. Camera signals (PCLK, VSYNC, HREF, D[7:0]) are sampled in the system clock domain, and their edges are detected internally. The detected edges are used to frame each image, pair bytes into RGB565 pixels, and generate linear write addresses. The block sits between the camera pins and the dual-port frame buffer that the VGA side reads.

## Interface
- H_PIXELS, 320, pixels stored per line
- V_LINES, 240, lines stored per frame
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES
- i_clk  in  1  system clock; its frequency must be ≥ 4× PCLK
- i_reset_n  in  1  asynchronous active-low reset
- i_pclk  in  1  camera pixel clock, asynchronous to i_clk
- i_vsync  in  1  camera VSYNC; high during vertical blanking
- i_href  in  1  camera HREF; high while line bytes are valid
- i_data  in  8  camera data byte; stable at the i_pclk rising edge
- i_capture_en  in  1  level; high = capture frames continuously
- o_wr_en  out  1  one-cycle frame buffer write strobe
- o_wr_addr  out  ADDR_W  write address
- o_wr_data  out  16  RGB565 pixel: {first byte, second byte}
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_cnt  out  8  completed frames; wraps 255→0
- o_busy  out  1  high when state ≠ IDLE
- o_err  out  1  sticky format error flag

## Operation
- **Synchronisation:** i_pclk, i_vsync, i_href and i_data pass through two-flop synchronisers of equal depth. A third register per control signal holds the previous synced value.
- **Edge detection:** a rising edge is synced=1 and prev=0; a falling edge is synced=0 and prev=1. Data is taken from the synced data stage aligned with the synced pclk.
- **States:** IDLE, ARMED, FRAME.
  - IDLE → ARMED when i_capture_en=1. o_err clears on this transition.
  - ARMED → FRAME on a vsync falling edge. Line counter, pixel counter, byte phase and line base are all zeroed.
  - FRAME → ARMED on a vsync rising edge if i_capture_en=1; otherwise FRAME → IDLE. o_frame_done pulses and o_frame_cnt increments on this transition.
- **In FRAME, on a pclk rising edge with synced href=1:**
  - Phase 0: latch the byte as the high byte; phase → 1.
  - Phase 1: form the pixel and set phase → 0. If pix_cnt < H_PIXELS and line_cnt < V_LINES:
    - o_wr_en=1
    - o_wr_addr = line_base + pix_cnt
    - o_wr_data = {high, byte}
  - After a phase-1 byte, pix_cnt increments whether or not the pixel was written.
- **Dropped pixels:** pixels with pix_cnt ≥ H_PIXELS, or in lines with line_cnt ≥ V_LINES, are not written and set o_err.
- **On an href falling edge in FRAME:**
  - line_cnt increments (saturates at V_LINES) and pix_cnt → 0.
  - line_base += H_PIXELS (no multiplier), only while line_cnt < V_LINES.
  - If phase=1 (odd byte count): the orphan byte is dropped, phase → 0, and o_err is set.
- **Short lines:** lines with fewer than H_PIXELS pixels leave their remaining addresses unwritten. The next line still starts at line_base + H_PIXELS.
- **Simultaneous events:**
  - A vsync rising edge in the same cycle as a pclk edge takes priority; no write occurs.
  - A pclk edge and an href falling edge in the same cycle: the byte is processed only if the synced href used for that cycle was 1; the line-end update is then applied.
- **Disable mid-frame:** i_capture_en falling during FRAME does not abort. The current frame completes, then the block returns to IDLE.
- **Edges outside FRAME:** pclk and href edges in IDLE or ARMED are ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, all counters and sync registers 0.
- **Reset mid-frame:** the same values apply immediately and asynchronously. No write is issued on the release cycle.
- **Write latency:** i_pclk first sampled high at i_clk edge k. The synced signal is 1 after edge k+1, and the edge is detected in the cycle k+1→k+2.
  - o_wr_en rises at edge k+2 and is exactly one cycle wide.
  - o_wr_addr and o_wr_data are valid in the same cycle as o_wr_en and held until the next write.
- **Frame end:** o_frame_done rises at edge k+2 after the vsync rise is first sampled at edge k. o_frame_cnt updates at that same edge.
- **Write rate:** at most one write per two pclk periods, i.e. ≥ 8 i_clk cycles apart.

## Test plan
- **Reset:** assert i_reset_n=0 mid-frame with writes active → all outputs 0 at once, state IDLE, no write after release until the next vsync fall.
- **Normal 4×2 frame:** H_PIXELS=4, V_LINES=2, capture_en=1, vsync fall, two lines of 8 bytes 0x00..0x0F → 8 writes.
  - Addresses 0..7; data 0x0001, 0x0203, …, 0x0E0F.
  - o_frame_done pulses once at the vsync rise; o_frame_cnt=1; o_err=0.
- **Latency:** one pclk rise with known sampling edge k → o_wr_en high exactly in cycle k+2..k+3.
- **Overflow:**
  - A line of 6 pixels with H_PIXELS=4 → writes at addresses 0..3 only; o_err=1; the next line starts at address 4.
  - A 3rd line with V_LINES=2 → no writes.
- **Odd byte:** a line with 7 bytes → 3 writes, the orphan byte is dropped, o_err=1.
- **Disable and wrap:**
  - capture_en drops mid-frame → the frame completes (frame_done pulses), then o_busy=0.
  - 256 frames → o_frame_cnt wraps to 0.
